// File: rtl/soric_wb_multicore_bridge.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// soric_wb_multicore_bridge
// Wishbone fan-out from the Caravel management slave port to NUM_CORES
// soric_core ports. The address decode is registered, each access has a
// timeout, and unmapped or timed-out accesses are still acknowledged with
// marker data. Core interrupts are folded onto the Caravel user IRQ lines.
//
// Optional feature macro: SORIC_BRIDGE_STATUS_EN
//   When defined, core index NUM_CORES (with BASE_HI matched) selects an
//   internal status register holding a timeout count, the last timed-out
//   index and the sticky timeout flag. A write with sel[0]=1 clears them.
//   When undefined, that index is unmapped and the sticky flag clears only
//   on reset.
// ---------------------------------------------------------------------------
module soric_wb_multicore_bridge #(
    parameter int         NUM_CORES = 4,
    parameter logic [7:0] BASE_HI   = 8'h30,
    parameter int         SEL_LSB   = 16,
    parameter int         TIMEOUT   = 255
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_ni,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_we_i,
    input  logic [3:0]                wbs_sel_i,
    input  logic [31:0]               wbs_dat_i,
    input  logic [31:0]               wbs_adr_i,
    output logic                      wbs_ack_o,
    output logic [31:0]               wbs_dat_o,
    output logic [NUM_CORES-1:0]      m_cyc_o,
    output logic [NUM_CORES-1:0]      m_stb_o,
    output logic                      m_we_o,
    output logic [3:0]                m_sel_o,
    output logic [31:0]               m_adr_o,
    output logic [31:0]               m_dat_o,
    input  logic [32*NUM_CORES-1:0]   m_dat_i,
    input  logic [NUM_CORES-1:0]      m_ack_i,
    input  logic [NUM_CORES-1:0]      core_irq_i,
    output logic [2:0]                user_irq_o
);

    localparam int          IDXW           = $clog2(NUM_CORES + 1);
    localparam logic [31:0] NCORES_W       = 32'(NUM_CORES);
    localparam logic [15:0] TIMEOUT_W      = 16'(TIMEOUT);
    localparam logic [31:0] RDATA_UNMAPPED = 32'hBADA_DD00;
    localparam logic [31:0] RDATA_TIMEOUT  = 32'hDEAD_DEAD;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // One-hot core strobe vector for a core index; out-of-range gives zero.
    function automatic logic [NUM_CORES-1:0] idx_onehot(input logic [IDXW-1:0] idx);
        logic [NUM_CORES-1:0] oh;
        oh = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (idx == IDXW'(k)) begin
                oh[k] = 1'b1;
            end else begin
                oh[k] = 1'b0;
            end
        end
        return oh;
    endfunction

    state_t                 state_r;
    state_t                 state_nxt_s;

    logic [IDXW-1:0]        adr_idx_s;
    logic [31:0]            idx_ext_s;
    logic                   base_hit_s;
    logic                   mapped_s;
    logic                   status_hit_s;
    logic [31:0]            status_word_s;
    logic                   req_s;
    logic                   accept_s;
    logic                   core_ack_s;
    logic [31:0]            core_rdata_s;
    logic                   to_hit_s;
    logic                   ack_evt_s;
    logic                   to_evt_s;
    logic [IDXW-1:0]        idx_nxt_s;
    logic [NUM_CORES-1:0]   stb_nxt_s;
    logic [31:0]            rdata_nxt_s;

    logic [IDXW-1:0]        idx_r;
    logic [31:0]            adr_r;
    logic [31:0]            dat_r;
    logic [3:0]             sel_r;
    logic                   we_r;
    logic [NUM_CORES-1:0]   stb_r;
    logic                   ack_r;
    logic [31:0]            rdata_r;
    logic [15:0]            cnt_r;
    logic                   sticky_r;
    logic                   irq_or_r;

    assign adr_idx_s  = wbs_adr_i[SEL_LSB +: IDXW];
    assign idx_ext_s  = {{(32-IDXW){1'b0}}, adr_idx_s};
    assign base_hit_s = (wbs_adr_i[31:24] == BASE_HI);
    assign mapped_s   = base_hit_s && (idx_ext_s < NCORES_W);
    assign req_s      = wbs_cyc_i && wbs_stb_i;
    assign accept_s   = (state_r == ST_IDLE) && req_s;
    assign to_hit_s   = (cnt_r == TIMEOUT_W);
    // Abort (cyc dropped) takes priority; an ack beats a same-cycle timeout.
    assign ack_evt_s  = (state_r == ST_REQ) && wbs_cyc_i && core_ack_s;
    assign to_evt_s   = (state_r == ST_REQ) && wbs_cyc_i && !core_ack_s && to_hit_s;

`ifdef SORIC_BRIDGE_STATUS_EN
    logic [15:0]     to_count_r;
    logic [IDXW-1:0] last_to_idx_r;
    logic            status_clr_s;

    assign status_hit_s  = base_hit_s && (idx_ext_s == NCORES_W);
    assign status_clr_s  = accept_s && status_hit_s && wbs_we_i && wbs_sel_i[0];
    assign status_word_s = {to_count_r, {(8-IDXW){1'b0}}, last_to_idx_r, 7'b0, sticky_r};

    // Saturating timeout count and last timed-out core index, clearable by write.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            to_count_r    <= 16'd0;
            last_to_idx_r <= '0;
        end else if (to_evt_s) begin
            to_count_r    <= (to_count_r == 16'hFFFF) ? to_count_r : to_count_r + 16'd1;
            last_to_idx_r <= idx_r;
        end else if (status_clr_s) begin
            to_count_r    <= 16'd0;
            last_to_idx_r <= '0;
        end else begin
            to_count_r    <= to_count_r;
            last_to_idx_r <= last_to_idx_r;
        end
    end

    // Sticky timeout flag: set by any timeout, cleared by a status write.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sticky_r <= 1'b0;
        end else if (to_evt_s) begin
            sticky_r <= 1'b1;
        end else if (status_clr_s) begin
            sticky_r <= 1'b0;
        end else begin
            sticky_r <= sticky_r;
        end
    end
`else
    assign status_hit_s  = 1'b0;
    assign status_word_s = 32'h0000_0000;

    // Sticky timeout flag: set by any timeout, cleared only by reset.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sticky_r <= 1'b0;
        end else if (to_evt_s) begin
            sticky_r <= 1'b1;
        end else begin
            sticky_r <= sticky_r;
        end
    end
`endif

    // Select the ack and read data of the currently addressed core.
    always_comb begin
        core_ack_s   = 1'b0;
        core_rdata_s = 32'h0000_0000;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (idx_r == IDXW'(k)) begin
                core_ack_s   = m_ack_i[k];
                core_rdata_s = m_dat_i[32*k +: 32];
            end else begin
                core_ack_s   = core_ack_s;
                core_rdata_s = core_rdata_s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    state_nxt_s = mapped_s ? ST_REQ : ST_RESP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (!wbs_cyc_i) begin
                    state_nxt_s = ST_IDLE;
                end else if (core_ack_s || to_hit_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output logic: next response data and next core strobe vector.
    always_comb begin
        idx_nxt_s   = idx_r;
        rdata_nxt_s = rdata_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    idx_nxt_s = adr_idx_s;
                    if (status_hit_s) begin
                        rdata_nxt_s = status_word_s;
                    end else if (!mapped_s) begin
                        rdata_nxt_s = RDATA_UNMAPPED;
                    end else begin
                        rdata_nxt_s = rdata_r;
                    end
                end else begin
                    idx_nxt_s = idx_r;
                end
            end
            ST_REQ: begin
                if (ack_evt_s) begin
                    rdata_nxt_s = core_rdata_s;
                end else if (to_evt_s) begin
                    rdata_nxt_s = RDATA_TIMEOUT;
                end else begin
                    rdata_nxt_s = rdata_r;
                end
            end
            default: rdata_nxt_s = rdata_r;
        endcase
        stb_nxt_s = (state_nxt_s == ST_REQ) ? idx_onehot(idx_nxt_s) : '0;
    end

    // Latch the accepted request onto the shared downstream bus.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            idx_r <= '0;
            adr_r <= 32'h0000_0000;
            dat_r <= 32'h0000_0000;
            sel_r <= 4'h0;
            we_r  <= 1'b0;
        end else if (accept_s) begin
            idx_r <= adr_idx_s;
            adr_r <= wbs_adr_i;
            dat_r <= wbs_dat_i;
            sel_r <= wbs_sel_i;
            we_r  <= wbs_we_i;
        end else begin
            idx_r <= idx_r;
            adr_r <= adr_r;
            dat_r <= dat_r;
            sel_r <= sel_r;
            we_r  <= we_r;
        end
    end

    // Registered strobe, upstream ack and response data.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            stb_r   <= '0;
            ack_r   <= 1'b0;
            rdata_r <= 32'h0000_0000;
        end else begin
            stb_r   <= stb_nxt_s;
            ack_r   <= (state_nxt_s == ST_RESP);
            rdata_r <= rdata_nxt_s;
        end
    end

    // Per-access wait counter, restarted on acceptance and frozen at TIMEOUT.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cnt_r <= 16'd0;
        end else if (accept_s) begin
            cnt_r <= 16'd0;
        end else if ((state_r == ST_REQ) && !to_hit_s) begin
            cnt_r <= cnt_r + 16'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Registered OR of the core interrupt lines.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            irq_or_r <= 1'b0;
        end else begin
            irq_or_r <= |core_irq_i;
        end
    end

    assign m_cyc_o    = stb_r;
    assign m_stb_o    = stb_r;
    assign m_we_o     = we_r;
    assign m_sel_o    = sel_r;
    assign m_adr_o    = adr_r;
    assign m_dat_o    = dat_r;
    assign wbs_ack_o  = ack_r;
    assign wbs_dat_o  = rdata_r;
    assign user_irq_o = {1'b0, sticky_r, irq_or_r};

endmodule

// File: tb/tb_soric_wb_multicore_bridge.sv
`timescale 1ns/1ps
// Directed table-driven bench for soric_wb_multicore_bridge (NUM_CORES=4,
// TIMEOUT=255) plus hand sequences for abort, IRQs and mid-transfer reset.
module tb_soric_wb_multicore_bridge;

    logic         clk;
    logic         rst_n;
    logic         wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]   wbs_sel_i;
    logic [31:0]  wbs_dat_i, wbs_adr_i;
    logic         wbs_ack_o;
    logic [31:0]  wbs_dat_o;
    logic [3:0]   m_cyc_o, m_stb_o;
    logic         m_we_o;
    logic [3:0]   m_sel_o;
    logic [31:0]  m_adr_o, m_dat_o;
    logic [127:0] m_dat_i;
    logic [3:0]   m_ack_i;
    logic [3:0]   core_irq_i;
    logic [2:0]   user_irq_o;

    int tests = 0;
    int fails = 0;

    soric_wb_multicore_bridge dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .m_cyc_o    (m_cyc_o),
        .m_stb_o    (m_stb_o),
        .m_we_o     (m_we_o),
        .m_sel_o    (m_sel_o),
        .m_adr_o    (m_adr_o),
        .m_dat_o    (m_dat_o),
        .m_dat_i    (m_dat_i),
        .m_ack_i    (m_ack_i),
        .core_irq_i (core_irq_i),
        .user_irq_o (user_irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        int          delay;     // stb cycles before the core acks; -1 = never
        logic [31:0] rdata;     // data presented by the target core
        logic [31:0] exp_dat;
        int          exp_lat;   // cycles from acceptance to wbs_ack_o
        logic [3:0]  exp_mask;  // OR of all m_stb_o seen
        int          exp_cyc;   // cycles with any m_stb_o high
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int          tgt;
        int          seen;
        int          lat;
        int          scyc;
        logic [3:0]  mask;
        logic [31:0] got_dat;
        logic [3:0]  ack_mask;
        bit          done;
        tgt = int'(v.adr[18:16]);
        for (int k = 0; k < 4; k++) m_dat_i[32*k +: 32] = 32'h1111_1111 * (k + 1);
        if (tgt < 4) m_dat_i[32*tgt +: 32] = v.rdata;
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = v.we;
        wbs_sel_i = 4'hF; wbs_adr_i = v.adr; wbs_dat_i = v.dat;
        seen = 0; lat = 0; scyc = 0; mask = 4'h0; got_dat = 32'h0; done = 1'b0;
        for (int c = 1; c <= 400 && !done; c++) begin
            @(negedge clk);
            ack_mask = 4'h0;
            if (c == 1) begin
                chk({v.name, ".adr"}, m_adr_o, v.adr);
                chk({v.name, ".mdat"}, m_dat_o, v.dat);
                chk({v.name, ".we"}, {31'd0, m_we_o}, {31'd0, v.we});
            end
            if (wbs_ack_o) begin
                lat = c; done = 1'b1; got_dat = wbs_dat_o;
                wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
            end else begin
                mask = mask | m_stb_o;
                if (m_stb_o != 4'h0) begin
                    scyc++;
                    if (tgt < 4) begin
                        if (m_stb_o[tgt]) begin
                            seen++;
                            if (v.delay >= 0 && seen == v.delay + 1) ack_mask[tgt] = 1'b1;
                        end
                    end
                end
            end
            m_ack_i = ack_mask;
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL %s.ack_wait: got no ack expected ack within 400 cycles", v.name);
            wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; m_ack_i = 4'h0;
        end
        chk({v.name, ".lat"}, 32'(lat), 32'(v.exp_lat));
        chk({v.name, ".dat"}, got_dat, v.exp_dat);
        chk({v.name, ".stbmask"}, {28'd0, mask}, {28'd0, v.exp_mask});
        chk({v.name, ".stbcyc"}, 32'(scyc), 32'(v.exp_cyc));
        @(negedge clk);
        chk({v.name, ".ack1cyc"}, {31'd0, wbs_ack_o}, 32'd0);
        chk({v.name, ".dathold"}, wbs_dat_o, v.exp_dat);
    endtask

    initial begin
        logic [31:0] status_exp;
        int          stray;
`ifdef SORIC_BRIDGE_STATUS_EN
        status_exp = 32'h0001_0001;   // one timeout, last index 0, sticky set
`else
        status_exp = 32'hBADA_DD00;
`endif
        vecs[0] = '{"wr_c1",   32'h3001_0004, 32'h1234_5678, 1'b1,  0, 32'h5555_0001, 32'h5555_0001,   2, 4'b0010,   1};
        vecs[1] = '{"rd_c3",   32'h3003_0000, 32'h0,         1'b0,  5, 32'hCAFE_F00D, 32'hCAFE_F00D,   7, 4'b1000,   6};
        vecs[2] = '{"rd_c2",   32'h3002_0008, 32'h0,         1'b0,  2, 32'hA5A5_5A5A, 32'hA5A5_5A5A,   4, 4'b0100,   3};
        vecs[3] = '{"to_c0",   32'h3000_0000, 32'h0,         1'b0, -1, 32'h7777_7777, 32'hDEAD_DEAD, 257, 4'b0001, 256};
        vecs[4] = '{"unm_hi",  32'h2000_0000, 32'h0,         1'b0,  0, 32'h0,         32'hBADA_DD00,   1, 4'b0000,   0};
        vecs[5] = '{"unm_i5",  32'h3005_0000, 32'h0,         1'b0,  0, 32'h0,         32'hBADA_DD00,   1, 4'b0000,   0};
        vecs[6] = '{"idx_n",   32'h3004_0000, 32'h0,         1'b0,  0, 32'h0,         status_exp,      1, 4'b0000,   0};
        vecs[7] = '{"rd_c1",   32'h3001_0010, 32'h0,         1'b0,  1, 32'h1357_9BDF, 32'h1357_9BDF,   3, 4'b0010,   2};

        rst_n = 1'b0;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_dat_i = 32'h0; wbs_adr_i = 32'h0;
        m_dat_i = 128'h0; m_ack_i = 4'h0; core_irq_i = 4'h0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst.ack", {31'd0, wbs_ack_o}, 32'd0);
        chk("rst.dat", wbs_dat_o, 32'h0);
        chk("rst.stb", {24'd0, m_cyc_o, m_stb_o}, 32'h0);
        chk("rst.bus", m_adr_o | m_dat_o | {27'd0, m_sel_o, m_we_o}, 32'h0);
        chk("rst.irq", {29'd0, user_irq_o}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
            if (i == 3) chk("to.irq1", {29'd0, user_irq_o}, 32'h2);
        end
        chk("irq.sticky", {29'd0, user_irq_o}, 32'h2);

        // Core IRQ aggregation with one cycle of latency
        @(negedge clk);
        core_irq_i = 4'b0100;
        @(negedge clk);
        chk("irq.or_set", {31'd0, user_irq_o[0]}, 32'd1);
        core_irq_i = 4'b0000;
        @(negedge clk);
        chk("irq.or_clr", {31'd0, user_irq_o[0]}, 32'd0);
        chk("irq.bit2", {31'd0, user_irq_o[2]}, 32'd0);

        // Wrong-line ack ignored, then master abort followed by a late ack
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3002_0000;
        @(negedge clk);
        chk("abort.stb", {28'd0, m_stb_o}, 32'h4);
        m_ack_i = 4'b0010;
        @(negedge clk);
        chk("abort.wrongack_stb", {28'd0, m_stb_o}, 32'h4);
        chk("abort.wrongack_ack", {31'd0, wbs_ack_o}, 32'd0);
        m_ack_i = 4'b0000; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(negedge clk);
        chk("abort.idle_stb", {24'd0, m_cyc_o, m_stb_o}, 32'h0);
        m_ack_i = 4'b0100;
        stray = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            m_ack_i = 4'b0000;
            if (wbs_ack_o) stray++;
        end
        chk("abort.no_ack", 32'(stray), 32'd0);
        run_vec(vecs[7]);

        // Reset asserted in the middle of a request
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = 32'h3001_0000; wbs_dat_i = 32'hFEED_BEEF;
        @(negedge clk);
        @(negedge clk);
        chk("mrst.pre_stb", {28'd0, m_stb_o}, 32'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst.stb", {24'd0, m_cyc_o, m_stb_o}, 32'h0);
        chk("mrst.ack", {31'd0, wbs_ack_o}, 32'd0);
        chk("mrst.bus", m_adr_o | m_dat_o | {27'd0, m_sel_o, m_we_o}, 32'h0);
        chk("mrst.irq", {29'd0, user_irq_o}, 32'h0);
        chk("mrst.dat", wbs_dat_o, 32'h0);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[2]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
